// File: rtl/crl78hcapbbctl_if.sv
// Break-box handshake bundle between the on-chip debugger and the
// RL78 capture-macro break controller.
interface crl78hcapbbctl_if #(
  parameter int CNTW = 8
);
  logic            ocd_bbreq;
  logic            ocd_clkstable;
  logic            capmx_bbmode;
  logic            ocd_bback;
  logic            bb_busy;
  logic            bb_tmo;
  logic [CNTW-1:0] bb_entcnt;

  modport master (
    output ocd_bbreq,
    output ocd_clkstable,
    input  capmx_bbmode,
    input  ocd_bback,
    input  bb_busy,
    input  bb_tmo,
    input  bb_entcnt
  );

  modport slave (
    input  ocd_bbreq,
    input  ocd_clkstable,
    output capmx_bbmode,
    output ocd_bback,
    output bb_busy,
    output bb_tmo,
    output bb_entcnt
  );
endinterface

// File: rtl/crl78hcapbbctl.sv
// RL78 break-box entry/exit controller: syncs the debugger request,
// sequences setup / clock-stable wait, and gates break mode and ack.
module crl78hcapbbctl #(
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 4,
  parameter int HOLD_CYC    = 4,
  parameter int TMO_CYC     = 255,
  parameter int CNTW        = 8
) (
  input  logic            clk_fclk,
  input  logic            rst_resb,
  input  logic            mod_scanmode,
  crl78hcapbbctl_if.slave bb
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAITSTB,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TMO_CYC - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [7:0]             ph_q;
  logic [7:0]             ph_d;
  logic                   tmo_q;
  logic                   tmo_d;
  logic [CNTW-1:0]        cnt_q;
  logic [CNTW-1:0]        cnt_d;
  logic                   mode_q;
  logic                   ack_q;
  logic                   timeout;
  logic                   inc;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && !tmo_q)
          state_d = SETUP;
      end
      SETUP: begin
        if (!req_s)
          state_d = IDLE;
        else if (ph_q == SETUP_LAST)
          state_d = WAITSTB;
      end
      WAITSTB: begin
        // timeout outranks a same-edge abort so the flag is kept
        if (!bb.ocd_clkstable && ph_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else if (!req_s) begin
          state_d = IDLE;
        end else if (bb.ocd_clkstable) begin
          inc     = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!req_s)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (ph_q == HOLD_LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mod_scanmode) begin
      state_d = IDLE;
      timeout = 1'b0;
      inc     = 1'b0;
    end

    ph_d = ph_q + 8'd1;
    if (mod_scanmode || state_d != state_q || state_q == IDLE)
      ph_d = '0;

    tmo_d = tmo_q;
    if (!mod_scanmode && !req_s)
      tmo_d = 1'b0;
    if (timeout)
      tmo_d = 1'b1;

    cnt_d = cnt_q;
    if (inc && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_fclk or negedge rst_resb) begin
    if (!rst_resb) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ph_q    <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bb.ocd_bbreq};
      state_q <= state_d;
      ph_q    <= ph_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      mode_q  <= (state_d == ACTIVE);
      ack_q   <= (state_d == ACTIVE) || (state_d == DRAIN);
    end
  end

  assign bb.capmx_bbmode = mode_q;
  assign bb.ocd_bback    = ack_q;
  assign bb.bb_busy      = (state_q != IDLE);
  assign bb.bb_tmo       = tmo_q;
  assign bb.bb_entcnt    = cnt_q;

endmodule

// File: tb/tb_crl78hcapbbctl.sv
// Bench for crl78hcapbbctl: vector table, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_crl78hcapbbctl;

  logic clk_fclk = 1'b0;
  logic rst_resb;
  logic scan_a;
  logic scan_b;

  crl78hcapbbctl_if #(.CNTW(8)) ba ();
  crl78hcapbbctl_if #(.CNTW(2)) bq ();

  crl78hcapbbctl #(
    .SYNC_STAGES(2), .SETUP_CYC(4), .HOLD_CYC(4),
    .TMO_CYC(255), .CNTW(8)
  ) dut_a (
    .clk_fclk     (clk_fclk),
    .rst_resb     (rst_resb),
    .mod_scanmode (scan_a),
    .bb           (ba.slave)
  );

  crl78hcapbbctl #(
    .SYNC_STAGES(2), .SETUP_CYC(4), .HOLD_CYC(4),
    .TMO_CYC(10), .CNTW(2)
  ) dut_b (
    .clk_fclk     (clk_fclk),
    .rst_resb     (rst_resb),
    .mod_scanmode (scan_b),
    .bb           (bq.slave)
  );

  always #5 clk_fclk = ~clk_fclk;

  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_fclk);
    #1;
  endtask

  typedef struct {
    bit req;
    bit stb;
    bit mode;
    bit ack;
    bit busy;
  } vec_t;

  // reference model: phases 0 idle,1 setup,2 wait,3 active,4 drain
  typedef struct {
    bit [3:0] hist;
    int       ph;
    int       left;
    bit       tmo;
    int       cnt;
  } mdl_t;

  function automatic mdl_t mstep(mdl_t m, bit req, bit stb, bit scan,
                                 int ss, int su, int hd, int to,
                                 int cmax);
    mdl_t n;
    bit   rs;
    bit   fired;
    n     = m;
    rs    = m.hist[ss-1];
    fired = 0;
    n.hist = {m.hist[2:0], req};
    if (scan) begin
      n.ph = 0;
    end else begin
      case (m.ph)
        0: if (rs && !m.tmo) begin n.ph = 1; n.left = su; end
        1: begin
          if (!rs) n.ph = 0;
          else if (m.left == 1) begin n.ph = 2; n.left = to; end
          else n.left = m.left - 1;
        end
        2: begin
          if (!stb && m.left == 1) begin n.ph = 0; fired = 1; end
          else if (!rs) n.ph = 0;
          else if (stb) begin
            n.ph = 3;
            if (m.cnt < cmax) n.cnt = m.cnt + 1;
          end else n.left = m.left - 1;
        end
        3: if (!rs) begin n.ph = 4; n.left = hd; end
        default: begin
          if (m.left == 1) n.ph = 0;
          else n.left = m.left - 1;
        end
      endcase
      if (!rs) n.tmo = 0;
      if (fired) n.tmo = 1;
    end
    return n;
  endfunction

  task automatic cmp_a(mdl_t m);
    chk("rnd_a_mode", ba.capmx_bbmode, m.ph == 3);
    chk("rnd_a_ack", ba.ocd_bback, m.ph == 3 || m.ph == 4);
    chk("rnd_a_busy", ba.bb_busy, m.ph != 0);
    chk("rnd_a_tmo", ba.bb_tmo, m.tmo);
    chk("rnd_a_cnt", ba.bb_entcnt, m.cnt);
  endtask

  task automatic cmp_b(mdl_t m);
    chk("rnd_b_mode", bq.capmx_bbmode, m.ph == 3);
    chk("rnd_b_ack", bq.ocd_bback, m.ph == 3 || m.ph == 4);
    chk("rnd_b_busy", bq.bb_busy, m.ph != 0);
    chk("rnd_b_tmo", bq.bb_tmo, m.tmo);
    chk("rnd_b_cnt", bq.bb_entcnt, m.cnt);
  endtask

  task automatic pulse_reset();
    ba.ocd_bbreq = 0;
    bq.ocd_bbreq = 0;
    scan_a = 0;
    scan_b = 0;
    #2 rst_resb = 0;
    #3 rst_resb = 1;
    step();
  endtask

  vec_t tv[15];
  mdl_t ma;
  mdl_t mb;
  bit   seen;

  initial begin
    tv = '{
      '{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 1},
      '{1, 1, 0, 0, 1}, '{1, 1, 0, 0, 1}, '{1, 1, 0, 0, 1},
      '{1, 1, 0, 0, 1}, '{1, 1, 1, 1, 1},
      '{0, 1, 1, 1, 1}, '{0, 1, 1, 1, 1}, '{0, 1, 0, 1, 1},
      '{0, 1, 0, 1, 1}, '{0, 1, 0, 1, 1}, '{0, 1, 0, 1, 1},
      '{0, 1, 0, 0, 0}
    };
    rst_resb = 0;
    scan_a = 0;
    scan_b = 0;
    ba.ocd_bbreq = 0;
    ba.ocd_clkstable = 0;
    bq.ocd_bbreq = 0;
    bq.ocd_clkstable = 0;
    #2;
    chk("rst_mode", ba.capmx_bbmode, 0);
    chk("rst_ack", ba.ocd_bback, 0);
    chk("rst_busy", ba.bb_busy, 0);
    chk("rst_tmo", ba.bb_tmo, 0);
    chk("rst_cnt", ba.bb_entcnt, 0);
    #10 rst_resb = 1;

    // entry then exit, one row per edge
    for (int i = 0; i < 15; i++) begin
      ba.ocd_bbreq = tv[i].req;
      ba.ocd_clkstable = tv[i].stb;
      step();
      chk($sformatf("tv%0d_mode", i), ba.capmx_bbmode, tv[i].mode);
      chk($sformatf("tv%0d_ack", i), ba.ocd_bback, tv[i].ack);
      chk($sformatf("tv%0d_busy", i), ba.bb_busy, tv[i].busy);
    end
    chk("tv_cnt", ba.bb_entcnt, 1);

    // short request aborts inside SETUP
    ba.ocd_bbreq = 1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) ba.ocd_bbreq = 0;
      step();
      chk("abort_ack", ba.ocd_bback, 0);
      if (i == 5) chk("abort_busy5", ba.bb_busy, 1);
      if (i == 6) chk("abort_busy6", ba.bb_busy, 0);
    end
    chk("abort_cnt", ba.bb_entcnt, 1);

    // scan override from ACTIVE
    ba.ocd_bbreq = 1;
    repeat (8) step();
    chk("scan_pre_mode", ba.capmx_bbmode, 1);
    scan_a = 1;
    step();
    chk("scan_mode", ba.capmx_bbmode, 0);
    chk("scan_ack", ba.ocd_bback, 0);
    chk("scan_busy", ba.bb_busy, 0);
    chk("scan_cnt", ba.bb_entcnt, 2);
    ba.ocd_bbreq = 0;
    repeat (3) step();
    scan_a = 0;
    repeat (3) step();
    chk("scan_post_busy", ba.bb_busy, 0);

    // async reset from ACTIVE
    ba.ocd_bbreq = 1;
    repeat (8) step();
    chk("ar_pre_mode", ba.capmx_bbmode, 1);
    #2 rst_resb = 0;
    #1;
    chk("ar_mode", ba.capmx_bbmode, 0);
    chk("ar_ack", ba.ocd_bback, 0);
    chk("ar_busy", ba.bb_busy, 0);
    chk("ar_cnt", ba.bb_entcnt, 0);
    ba.ocd_bbreq = 0;
    #2 rst_resb = 1;
    repeat (4) step();

    // timeout on the TMO_CYC=10 instance
    bq.ocd_clkstable = 0;
    bq.ocd_bbreq = 1;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      seen |= bq.capmx_bbmode;
      chk("tmo_pre", bq.bb_tmo, 0);
    end
    chk("tmo_busy16", bq.bb_busy, 1);
    step();
    chk("tmo_set", bq.bb_tmo, 1);
    chk("tmo_busy17", bq.bb_busy, 0);
    repeat (20) begin
      step();
      seen |= bq.capmx_bbmode;
      chk("tmo_hold_busy", bq.bb_busy, 0);
    end
    chk("tmo_never_mode", seen, 0);
    chk("tmo_still", bq.bb_tmo, 1);
    bq.ocd_bbreq = 0;
    repeat (2) step();
    chk("tmo_clr_early", bq.bb_tmo, 1);
    step();
    chk("tmo_clr", bq.bb_tmo, 0);
    step();
    bq.ocd_bbreq = 1;
    bq.ocd_clkstable = 1;
    repeat (7) step();
    chk("tmo_re7", bq.capmx_bbmode, 0);
    step();
    chk("tmo_re8", bq.capmx_bbmode, 1);
    chk("tmo_re_cnt", bq.bb_entcnt, 1);
    bq.ocd_bbreq = 0;
    repeat (8) step();
    chk("tmo_exit", bq.bb_busy, 0);

    // saturation of a 2-bit entry counter
    pulse_reset();
    bq.ocd_clkstable = 1;
    for (int i = 0; i < 5; i++) begin
      bq.ocd_bbreq = 1;
      repeat (8) step();
      chk("sat_mode", bq.capmx_bbmode, 1);
      chk($sformatf("sat_cnt%0d", i), bq.bb_entcnt, (i < 3) ? i + 1 : 3);
      bq.ocd_bbreq = 0;
      repeat (8) step();
    end

    // randomized run against the reference model
    pulse_reset();
    ma = '{default: 0};
    mb = '{default: 0};
    ba.ocd_clkstable = 1;
    bq.ocd_clkstable = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) ba.ocd_bbreq = ~ba.ocd_bbreq;
      if ($urandom_range(0, 9) == 0) bq.ocd_bbreq = ~bq.ocd_bbreq;
      if ($urandom_range(0, 11) == 0)
        ba.ocd_clkstable = ~ba.ocd_clkstable;
      if ($urandom_range(0, 11) == 0)
        bq.ocd_clkstable = ~bq.ocd_clkstable;
      scan_a = ($urandom_range(0, 59) == 0);
      scan_b = ($urandom_range(0, 59) == 0);
      ma = mstep(ma, ba.ocd_bbreq, ba.ocd_clkstable, scan_a,
                 2, 4, 4, 255, 255);
      mb = mstep(mb, bq.ocd_bbreq, bq.ocd_clkstable, scan_b,
                 2, 4, 4, 10, 3);
      step();
      cmp_a(ma);
      cmp_b(mb);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
